// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked multi-cycle ALU: opcodes, FSM encoding,
// flag bit positions and the divider sign fix-up record.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_EQ   = 4'hA;
  localparam logic [3:0] OP_GT   = 4'hB;
  localparam logic [3:0] OP_LT   = 4'hC;
  localparam logic [3:0] OP_SRL  = 4'hD;
  localparam logic [3:0] OP_SLL  = 4'hE;
  localparam logic [3:0] OP_SRA  = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int FLG_Z  = 0;
  localparam int FLG_C  = 1;
  localparam int FLG_V  = 2;
  localparam int FLG_DZ = 3;

  // Sign information kept while the unsigned divider core iterates.
  typedef struct packed {
    logic sgn;
    logic q_neg;
    logic r_neg;
  } div_fix_t;

endpackage

// File: rtl/alu_div_iter.sv
// Unsigned restoring divider: one quotient bit per cycle for W cycles. The final
// step's quotient/remainder are presented combinationally while done is high.
module alu_div_iter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [W:0]    partial, diff;
  logic          fits;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    partial   = {rem_q, quo_q[W-1]};
    diff      = partial - {1'b0, dvs_q};
    fits      = ~diff[W];
    remainder = fits ? diff[W-1:0] : partial[W-1:0];
    quotient  = {quo_q[W-2:0], fits};
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(W - 1));

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_hs_multicycle.sv
// Handshaked ALU with signed mode, flags and an iterative divider; single-cycle ops
// are registered at acceptance, division results when the divider finishes.
module alu_hs_multicycle
  import alu_pkg::*;
#(
  parameter int W    = 8,
  parameter int SH_W = $clog2(W)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [3:0]     ALU_FUN,
  input  logic           SIGNED_MD,
  input  logic           IN_VALID,
  output logic           IN_READY,
  output logic [2*W-1:0] ALU_OUT,
  output logic [3:0]     FLAGS,
  output logic           OUT_VALID,
  input  logic           OUT_READY
);

  logic [1:0]     state_q;
  logic [2*W-1:0] alu_out_q;
  logic [3:0]     flags_q;
  div_fix_t       fix_q, fix_n;

  logic           accept, is_div, div_busy, div_done, div_v;
  logic [W-1:0]   a_mag, b_mag, add_lo, q_mag, r_mag, q_fix, r_fix;
  logic [2*W-1:0] a_ext, b_ext, res;
  logic [3:0]     flg, div_flg;
  logic [SH_W-1:0] sh;

  assign IN_READY  = (state_q == ST_IDLE) && !div_busy;
  assign OUT_VALID = (state_q == ST_DONE);
  assign ALU_OUT   = alu_out_q;
  assign FLAGS     = flags_q;

  assign accept = IN_VALID && IN_READY;
  assign is_div = (ALU_FUN == OP_DIV) && (B != '0);
  assign sh     = B[SH_W-1:0];
  assign a_ext  = SIGNED_MD ? {{W{A[W-1]}}, A} : {{W{1'b0}}, A};
  assign b_ext  = SIGNED_MD ? {{W{B[W-1]}}, B} : {{W{1'b0}}, B};
  assign a_mag  = (SIGNED_MD && A[W-1]) ? -A : A;
  assign b_mag  = (SIGNED_MD && B[W-1]) ? -B : B;
  assign add_lo = A + B;

  always_comb begin
    fix_n.sgn   = SIGNED_MD;
    fix_n.q_neg = SIGNED_MD && (A[W-1] ^ B[W-1]);
    fix_n.r_neg = SIGNED_MD && A[W-1];
  end

  // Single-cycle datapath; the extended operands give exact 2W add/sub/mul/compare.
  always_comb begin
    res = '0;
    flg = '0;
    case (ALU_FUN)
      OP_ADD: begin
        res        = a_ext + b_ext;
        flg[FLG_C] = add_lo < A;
        flg[FLG_V] = SIGNED_MD && (res[W] ^ res[W-1]);
      end
      OP_SUB: begin
        res        = a_ext - b_ext;
        flg[FLG_C] = A < B;
        flg[FLG_V] = SIGNED_MD && (res[W] ^ res[W-1]);
      end
      OP_MUL:  res = a_ext * b_ext;
      OP_DIV:  flg[FLG_DZ] = 1'b1;
      OP_AND:  res[W-1:0] = A & B;
      OP_OR:   res[W-1:0] = A | B;
      OP_NAND: res[W-1:0] = ~(A & B);
      OP_NOR:  res[W-1:0] = ~(A | B);
      OP_XOR:  res[W-1:0] = A ^ B;
      OP_XNOR: res[W-1:0] = ~(A ^ B);
      OP_EQ:   res[1:0] = (A == B) ? 2'd1 : 2'd0;
      OP_GT:   res[1:0] = ($signed(a_ext) > $signed(b_ext)) ? 2'd2 : 2'd0;
      OP_LT:   res[1:0] = ($signed(a_ext) < $signed(b_ext)) ? 2'd3 : 2'd0;
      OP_SRL:  res[W-1:0] = A >> sh;
      OP_SLL:  res = {{W{1'b0}}, A} << sh;
      OP_SRA:  res[W-1:0] = $signed(A) >>> sh;
      default: res = '0;
    endcase
    flg[FLG_Z] = (res == '0);
  end

  alu_div_iter #(.W(W)) u_div (
    .CLK       (CLK),
    .RST       (RST),
    .start     (accept && is_div),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (q_mag),
    .remainder (r_mag)
  );

  // Only -2^(W-1) / -1 yields a non-negated quotient magnitude with the top bit set.
  assign q_fix = fix_q.q_neg ? -q_mag : q_mag;
  assign r_fix = fix_q.r_neg ? -r_mag : r_mag;
  assign div_v = fix_q.sgn && !fix_q.q_neg && q_mag[W-1];

  always_comb begin
    div_flg         = '0;
    div_flg[FLG_V]  = div_v;
    div_flg[FLG_Z]  = ({r_fix, q_fix} == '0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      alu_out_q <= '0;
      flags_q   <= '0;
      fix_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          fix_q <= fix_n;
          if (is_div) begin
            state_q <= ST_DIV;
          end else begin
            alu_out_q <= res;
            flags_q   <= flg;
            state_q   <= ST_DONE;
          end
        end
        ST_DIV: if (div_done) begin
          alu_out_q <= {r_fix, q_fix};
          flags_q   <= div_flg;
          state_q   <= ST_DONE;
        end
        ST_DONE: if (OUT_READY) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_hs_multicycle.sv
// Self-checking bench: directed vectors with literal expectations, then random
// traffic with backpressure scored against an integer-arithmetic model.
module tb_alu_hs_multicycle;
  import alu_pkg::*;

  localparam int W = 8;

  logic           CLK, RST;
  logic [W-1:0]   A, B;
  logic [3:0]     ALU_FUN;
  logic           SIGNED_MD, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [2*W-1:0] ALU_OUT;
  logic [3:0]     FLAGS;

  alu_hs_multicycle #(.W(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .ALU_FUN   (ALU_FUN),
    .SIGNED_MD (SIGNED_MD),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .ALU_OUT   (ALU_OUT),
    .FLAGS     (FLAGS),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the interpreted operand values.
  function automatic logic [19:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op, input logic sgn);
    int sa, sv, full, q, r, sh;
    logic [15:0] o;
    logic c, v, dz;
    sa = sgn ? int'($signed(a)) : int'(a);
    sv = sgn ? int'($signed(b)) : int'(b);
    sh = int'(b) % 8;
    o = 16'd0; c = 1'b0; v = 1'b0; dz = 1'b0; full = 0; q = 0; r = 0;
    case (op)
      OP_ADD: begin
        full = sa + sv; o = full[15:0];
        c = (int'(a) + int'(b)) > 255;
        v = sgn && (full > 127 || full < -128);
      end
      OP_SUB: begin
        full = sa - sv; o = full[15:0];
        c = a < b;
        v = sgn && (full > 127 || full < -128);
      end
      OP_MUL: begin full = sa * sv; o = full[15:0]; end
      OP_DIV: begin
        if (b == 8'd0) dz = 1'b1;
        else begin
          q = sa / sv; r = sa % sv;
          o = {r[7:0], q[7:0]};
          v = sgn && (q > 127);
        end
      end
      OP_AND:  o = {8'h00, a & b};
      OP_OR:   o = {8'h00, a | b};
      OP_NAND: o = {8'h00, ~(a & b)};
      OP_NOR:  o = {8'h00, ~(a | b)};
      OP_XOR:  o = {8'h00, a ^ b};
      OP_XNOR: o = {8'h00, ~(a ^ b)};
      OP_EQ:   o = (a == b) ? 16'd1 : 16'd0;
      OP_GT:   o = (sa > sv) ? 16'd2 : 16'd0;
      OP_LT:   o = (sa < sv) ? 16'd3 : 16'd0;
      OP_SRL:  o = 16'(int'(a) >> sh);
      OP_SLL:  o = 16'(int'(a) << sh);
      OP_SRA:  o = 16'((int'($signed(a)) >>> sh) & 255);
      default: o = 16'hDEAD;
    endcase
    return {dz, v, c, (o == 16'd0), o};
  endfunction

  typedef struct {
    logic [15:0] out;
    logic [3:0]  flg;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // Compare process: every cycle, ready/valid and held results against the scoreboard.
  always @(negedge CLK) begin
    logic        ev;
    logic [19:0] m;
    exp_t        e;
    cyc++;
    if (!RST) begin
      sb.delete();
      check("rst_out_valid", 32'(OUT_VALID), 32'd0);
      check("rst_alu_out", 32'(ALU_OUT), 32'd0);
      check("rst_flags", 32'(FLAGS), 32'd0);
    end else begin
      check("in_ready", 32'(IN_READY), 32'(sb.size() == 0));
      ev = (sb.size() > 0) && (cyc - sb[0].acc >= sb[0].lat);
      check("out_valid", 32'(OUT_VALID), 32'(ev));
      if (ev && OUT_VALID) begin
        check("alu_out", 32'(ALU_OUT), 32'(sb[0].out));
        check("flags", 32'(FLAGS), 32'(sb[0].flg));
        if (OUT_READY) void'(sb.pop_front());
      end
      if (IN_VALID && IN_READY) begin
        m     = model(A, B, ALU_FUN, SIGNED_MD);
        e.out = m[15:0];
        e.flg = m[19:16];
        e.acc = cyc;
        e.lat = (ALU_FUN == OP_DIV && B != 8'd0) ? W + 1 : 1;
        sb.push_back(e);
      end
    end
  end

  typedef struct {
    logic [7:0]  a, b;
    logic [3:0]  op;
    logic        sgn;
    logic [15:0] out;
    logic [3:0]  flg;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic sgn, input logic [15:0] out, input logic [3:0] flg,
                         input int lat);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.sgn = sgn; v.out = out; v.flg = flg; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge CLK);
    while (!OUT_VALID && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    check("valid_timeout", 32'(OUT_VALID), 32'd1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic sgn, output logic [15:0] out, output logic [3:0] flg,
                        output int lat);
    int n;
    @(posedge CLK); #1;
    A = a; B = b; ALU_FUN = op; SIGNED_MD = sgn; IN_VALID = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("accept_timeout", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0; A = 8'($urandom); B = 8'($urandom);
    wait_valid(lat);
    out = ALU_OUT;
    flg = FLAGS;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h7F;
      4: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] out;
    logic [3:0]  flg;
    int          lat;

    RST = 1'b0; A = '0; B = '0; ALU_FUN = '0; SIGNED_MD = 1'b0;
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("post_rst_in_ready", 32'(IN_READY), 32'd1);

    //        a      b      op       sgn   out       flags    lat
    add_vec(8'hFF, 8'h01, OP_ADD,  1'b0, 16'h0100, 4'b0010, 1);
    add_vec(8'hFF, 8'h01, OP_ADD,  1'b1, 16'h0000, 4'b0011, 1);
    add_vec(8'h7F, 8'h01, OP_ADD,  1'b1, 16'h0080, 4'b0100, 1);
    add_vec(8'h00, 8'h01, OP_SUB,  1'b0, 16'hFFFF, 4'b0010, 1);
    add_vec(8'h80, 8'h01, OP_SUB,  1'b1, 16'hFF7F, 4'b0100, 1);
    add_vec(8'hFF, 8'hFF, OP_MUL,  1'b0, 16'hFE01, 4'b0000, 1);
    add_vec(8'hFF, 8'hFF, OP_MUL,  1'b1, 16'h0001, 4'b0000, 1);
    add_vec(8'd200, 8'd7, OP_DIV,  1'b0, 16'h041C, 4'b0000, 9);
    add_vec(8'hF9, 8'h02, OP_DIV,  1'b1, 16'hFFFD, 4'b0000, 9);
    add_vec(8'h80, 8'hFF, OP_DIV,  1'b1, 16'h0080, 4'b0100, 9);
    add_vec(8'h55, 8'h00, OP_DIV,  1'b0, 16'h0000, 4'b1001, 1);
    add_vec(8'hF0, 8'h0F, OP_XNOR, 1'b0, 16'h0000, 4'b0001, 1);
    add_vec(8'h10, 8'h10, OP_EQ,   1'b0, 16'h0001, 4'b0000, 1);
    add_vec(8'hFF, 8'h01, OP_GT,   1'b0, 16'h0002, 4'b0000, 1);
    add_vec(8'hFF, 8'h01, OP_LT,   1'b1, 16'h0003, 4'b0000, 1);
    add_vec(8'h81, 8'h03, OP_SRL,  1'b0, 16'h0010, 4'b0000, 1);
    add_vec(8'h81, 8'h03, OP_SLL,  1'b0, 16'h0408, 4'b0000, 1);
    add_vec(8'h81, 8'h03, OP_SRA,  1'b0, 16'h00F0, 4'b0000, 1);
    add_vec(8'h03, 8'h08, OP_SRL,  1'b0, 16'h0003, 4'b0000, 1);

    foreach (vecs[i]) begin
      check($sformatf("model_vec%0d", i), 32'(model(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sgn)),
            32'({vecs[i].flg, vecs[i].out}));
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sgn, out, flg, lat);
      check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].out));
      check($sformatf("vec%0d_flags", i), 32'(flg), 32'(vecs[i].flg));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result held, no accept until DONE exits.
    @(posedge CLK); #1 OUT_READY = 1'b0;
    run_op(8'h21, 8'h43, OP_XOR, 1'b0, out, flg, lat);
    check("bp_first_out", 32'(out), 32'h0062);
    @(posedge CLK); #1;
    A = 8'h10; B = 8'h20; ALU_FUN = OP_ADD; SIGNED_MD = 1'b0; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_in_ready", 32'(IN_READY), 32'd0);
      check("bp_hold_out", 32'(ALU_OUT), 32'h0062);
      check("bp_hold_valid", 32'(OUT_VALID), 32'd1);
    end
    @(posedge CLK); #1 OUT_READY = 1'b1;
    @(negedge CLK);
    check("bp_release_c1", 32'(IN_READY), 32'd0);
    @(negedge CLK);
    check("bp_release_c2", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1 IN_VALID = 1'b0;
    wait_valid(lat);
    check("bp_second_out", 32'(ALU_OUT), 32'h0030);
    check("bp_second_lat", 32'(lat), 32'd1);

    // Reset while dividing: nonzero prior result must be cleared at once.
    run_op(8'h12, 8'h34, OP_ADD, 1'b0, out, flg, lat);
    check("pre_rst_out", 32'(out), 32'h0046);
    @(posedge CLK); #1;
    A = 8'd200; B = 8'd7; ALU_FUN = OP_DIV; SIGNED_MD = 1'b0; IN_VALID = 1'b1;
    @(negedge CLK);
    check("div_accept_ready", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1 IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check("mid_div_rst_valid", 32'(OUT_VALID), 32'd0);
    check("mid_div_rst_out", 32'(ALU_OUT), 32'd0);
    check("mid_div_rst_flags", 32'(FLAGS), 32'd0);
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    check("rel_in_ready", 32'(IN_READY), 32'd1);
    check("rel_out_valid", 32'(OUT_VALID), 32'd0);
    run_op(8'h05, 8'h03, OP_SUB, 1'b0, out, flg, lat);
    check("after_rst_out", 32'(out), 32'h0002);
    check("after_rst_lat", 32'(lat), 32'd1);

    // Random traffic with random backpressure; scored by the compare process.
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      IN_VALID  = ($urandom_range(0, 9) < 6);
      OUT_READY = ($urandom_range(0, 9) < 7);
      A         = pick();
      B         = pick();
      ALU_FUN   = 4'($urandom_range(0, 15));
      SIGNED_MD = 1'($urandom_range(0, 1));
    end
    @(posedge CLK); #1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    repeat (15) @(negedge CLK);
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
